// File: rtl/stdp_controller.sv
// Pair-based STDP controller: pairs pre/post spikes inside a bounded window and
// applies a saturating power-of-two weight delta. `STDP_LTD_EN enables depression.
module stdp_controller #(
    parameter logic [7:0]  W_INIT = 8'd1,
    parameter int unsigned WINDOW = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       learn_en,
    input  logic       pre_spike,
    input  logic       post_spike,
    output logic [7:0] weight,
    output logic [7:0] syn_current,
    output logic       w_upd,
    output logic [3:0] dt
);
    localparam int unsigned DT_W = 4;
    localparam int unsigned W_W  = 8;
    localparam logic [DT_W-1:0] DT_LAST = DT_W'(WINDOW - 1);

    typedef enum logic [1:0] {IDLE, PRE_WAIT, POST_WAIT, UPDATE} state_t;

    state_t         state;
    logic [W_W-1:0] delta;
    logic           ltp;

    logic [W_W-1:0] delta_c;
    logic [W_W:0]   sum_c;
    logic [W_W:0]   diff_c;

    // Power-of-two delta from the interval at the moment of pairing
    always_comb begin
        delta_c = W_W'(2);
        if (dt == DT_W'(1))
            delta_c = W_W'(16);
        else if (dt[3:2] == 2'b00)
            delta_c = W_W'(8);
        else if (dt[3] == 1'b0)
            delta_c = W_W'(4);
    end

    // 9-bit arithmetic so the carry/borrow bit drives the clamp
    always_comb begin
        sum_c  = {1'b0, weight} + {1'b0, delta};
        diff_c = {1'b0, weight} - {1'b0, delta};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            weight      <= W_INIT;
            syn_current <= '0;
            w_upd       <= 1'b0;
            dt          <= '0;
            delta       <= '0;
            ltp         <= 1'b1;
        end else begin
            syn_current <= pre_spike ? weight : '0;
            w_upd       <= 1'b0;
            case (state)
                IDLE: begin
                    dt <= '0;
                    if (learn_en) begin
                        if (pre_spike && !post_spike) begin
                            state <= PRE_WAIT;
                            dt    <= DT_W'(1);
                        end
`ifdef STDP_LTD_EN
                        else if (post_spike && !pre_spike) begin
                            state <= POST_WAIT;
                            dt    <= DT_W'(1);
                        end
`endif
                    end
                end
                PRE_WAIT: begin
                    if (!learn_en) begin
                        state <= IDLE;
                        dt    <= '0;
                    end else if (post_spike) begin
                        state <= UPDATE;
                        delta <= delta_c;
                        ltp   <= 1'b1;
                    end else if (pre_spike) begin
                        dt <= DT_W'(1);
                    end else if (dt == DT_LAST) begin
                        state <= IDLE;
                        dt    <= '0;
                    end else begin
                        dt <= dt + DT_W'(1);
                    end
                end
`ifdef STDP_LTD_EN
                POST_WAIT: begin
                    if (!learn_en) begin
                        state <= IDLE;
                        dt    <= '0;
                    end else if (pre_spike) begin
                        state <= UPDATE;
                        delta <= delta_c;
                        ltp   <= 1'b0;
                    end else if (post_spike) begin
                        dt <= DT_W'(1);
                    end else if (dt == DT_LAST) begin
                        state <= IDLE;
                        dt    <= '0;
                    end else begin
                        dt <= dt + DT_W'(1);
                    end
                end
`endif
                UPDATE: begin
                    if (ltp)
                        weight <= sum_c[W_W] ? {W_W{1'b1}} : sum_c[W_W-1:0];
                    else
                        weight <= diff_c[W_W] ? '0 : diff_c[W_W-1:0];
                    w_upd <= 1'b1;
                    state <= IDLE;
                    dt    <= '0;
                end
                default: begin
                    state <= IDLE;
                    dt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stdp_controller.sv
// Directed self-checking bench for stdp_controller (default WINDOW=16, W_INIT=1).
module tb_stdp_controller;
    logic       clk = 1'b0;
    logic       rst;
    logic       learn_en;
    logic       pre_spike;
    logic       post_spike;
    logic [7:0] weight;
    logic [7:0] syn_current;
    logic       w_upd;
    logic [3:0] dt;

    int n_checks = 0;
    int n_pass   = 0;
    int w_exp    = 1;

    stdp_controller dut (
        .clk         (clk),
        .rst         (rst),
        .learn_en    (learn_en),
        .pre_spike   (pre_spike),
        .post_spike  (post_spike),
        .weight      (weight),
        .syn_current (syn_current),
        .w_upd       (w_upd),
        .dt          (dt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int delta_of(input int gap);
        if (gap == 1) return 16;
        if (gap < 4)  return 8;
        if (gap < 8)  return 4;
        return 2;
    endfunction

    function automatic int ltp_w(input int w, input int gap);
        return (w + delta_of(gap) > 255) ? 255 : w + delta_of(gap);
    endfunction

    function automatic int ltd_w(input int w, input int gap);
        return (w - delta_of(gap) < 0) ? 0 : w - delta_of(gap);
    endfunction

    // First spike, partner `gap` edges later, then check the update two edges on
    task automatic pair(input bit pre_first, input int gap, input bit exp_upd,
                        input int exp_w, input int exp_dt1);
        int w_old;
        w_old = w_exp;
        if (pre_first) pre_spike = 1'b1; else post_spike = 1'b1;
        tick();
        pre_spike  = 1'b0;
        post_spike = 1'b0;
        check("dt_start", dt, exp_dt1);
        if (pre_first) check("syn_pulse", syn_current, w_old);
        repeat (gap - 1) tick();
        if (pre_first && gap > 1) check("syn_clear", syn_current, 0);
        if (pre_first) post_spike = 1'b1; else pre_spike = 1'b1;
        tick();
        pre_spike  = 1'b0;
        post_spike = 1'b0;
        if (!pre_first) check("syn_pulse_ltd", syn_current, w_old);
        tick();
        check("weight", weight, exp_w);
        check("w_upd", w_upd, exp_upd);
        tick();
        check("w_upd_clr", w_upd, 0);
        w_exp = exp_w;
    endtask

    initial begin
        rst        = 1'b1;
        learn_en   = 1'b1;
        pre_spike  = 1'b0;
        post_spike = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_weight", weight, 1);
        check("rst_syn", syn_current, 0);
        check("rst_w_upd", w_upd, 0);
        check("rst_dt", dt, 0);

        // LTP at dt=1, 5, 12: 1->17->21->23
        pair(1'b1, 1, 1'b1, 17, 1);
        pair(1'b1, 5, 1'b1, 21, 1);
        pair(1'b1, 12, 1'b1, 23, 1);

`ifdef STDP_LTD_EN
        pair(1'b0, 2, 1'b1, ltd_w(w_exp, 2), 1);
        check("ltd_value", weight, 15);
        pair(1'b0, 1, 1'b1, ltd_w(w_exp, 1), 1);
        check("ltd_clamp0", weight, 0);
`else
        // Post in IDLE is ignored; the following pre only opens a window
        post_spike = 1'b1;
        tick();
        post_spike = 1'b0;
        check("post_ignored_dt", dt, 0);
        tick();
        pre_spike = 1'b1;
        tick();
        pre_spike = 1'b0;
        check("pre_after_post_dt", dt, 1);
        repeat (20) tick();
        check("no_ltd_weight", weight, 23);
        check("no_ltd_dt", dt, 0);
`endif

        // Last legal interval dt=15 still pairs with delta 2
        pair(1'b1, 15, 1'b1, ltp_w(w_exp, 15), 1);

        // dt=16 times out: window closes at dt=15
        pre_spike = 1'b1;
        tick();
        pre_spike = 1'b0;
        repeat (14) tick();
        check("to_dt15", dt, 15);
        tick();
        check("to_dt0", dt, 0);
        post_spike = 1'b1;
        tick();
        post_spike = 1'b0;
        tick();
        tick();
        check("to_w_upd", w_upd, 0);
        check("to_weight", weight, w_exp);
        repeat (20) tick();

        // Simultaneous spikes in IDLE
        pre_spike  = 1'b1;
        post_spike = 1'b1;
        tick();
        pre_spike  = 1'b0;
        post_spike = 1'b0;
        check("sim_dt", dt, 0);
        check("sim_syn", syn_current, w_exp);
        tick();
        tick();
        check("sim_w_upd", w_upd, 0);
        check("sim_weight", weight, w_exp);

        // learn_en=0: syn_current still pulses, no learning
        learn_en = 1'b0;
        pair(1'b1, 1, 1'b0, w_exp, 0);
        learn_en = 1'b1;

        // Saturate upward, then one more pairing still pulses w_upd
        for (int i = 0; i < 20 && w_exp < 255; i++)
            pair(1'b1, 1, 1'b1, ltp_w(w_exp, 1), 1);
        pair(1'b1, 1, 1'b1, 255, 1);

        // Reset mid PRE_WAIT discards the pairing
        pre_spike = 1'b1;
        tick();
        pre_spike = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_weight", weight, 1);
        check("rstw_dt", dt, 0);
        check("rstw_syn", syn_current, 0);
        post_spike = 1'b1;
        tick();
        post_spike = 1'b0;
        tick();
        tick();
        check("rstw_w_upd", w_upd, 0);
        check("rstw_weight2", weight, 1);
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
